// File: rtl/run_ctrl.sv
// -----------------------------------------------------------------------------
// run_ctrl
//   Run-control responder sitting between the debug host and the PC/CPU pair.
//   Accepts STATUS/HALT/RESUME/STEP commands over a valid/ready channel, gates
//   the PC write enable, watches the CPU exception vector and returns one
//   registered status response (state, PC, cause) per accepted command. A trap
//   taken while running with nothing outstanding produces an unsolicited HALT
//   response, unless a response is already pending, in which case it is dropped.
//
//   state  | meaning
//   -------+----------------------------------------------------------------
//   RST    | first cycle out of reset, no commits, moves to RUN unconditionally
//   RUN    | free running, PC commits every exception-free cycle
//   HALT   | stopped by command or trap; accepts RESUME/STEP/HALT/STATUS
//   ERROR  | fatal anomaly seen; sticky until rst_i, commands only answered
//   STEP   | committing a bounded number of instructions, then back to HALT
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   cmd_valid_i/ready_o command handshake; cmd_op_i (0 STATUS,1 HALT,2 RESUME,
//                       3 STEP), cmd_arg_i step count (0 behaves as 1)
//   exception_i         CPU exception vector for the current cycle
//   pc_i                current PC
//   pc_we_o             PC commit enable
//   rsp_valid_o/ready_i response handshake; rsp_state_o, rsp_pc_o, rsp_cause_o
//   halted_o            state is HALT or ERROR
// -----------------------------------------------------------------------------
module run_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int ANOMALY_MSB = 2,
    parameter int ECALL_BIT   = 3,
    parameter int EBREAK_BIT  = 4,
    parameter int STEP_W      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [STEP_W-1:0]     cmd_arg_i,
    input  logic [7:0]            exception_i,
    input  logic [DATA_WIDTH-1:0] pc_i,
    output logic                  pc_we_o,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [2:0]            rsp_state_o,
    output logic [DATA_WIDTH-1:0] rsp_pc_o,
    output logic [7:0]            rsp_cause_o,
    output logic                  halted_o
);

    typedef enum logic [2:0] {
        S_RST   = 3'd0,
        S_RUN   = 3'd1,
        S_HALT  = 3'd2,
        S_ERROR = 3'd3,
        S_STEP  = 3'd4
    } state_t;

    localparam logic [1:0] OP_STATUS = 2'd0;
    localparam logic [1:0] OP_HALT   = 2'd1;
    localparam logic [1:0] OP_RESUME = 2'd2;
    localparam logic [1:0] OP_STEP   = 2'd3;

    localparam logic [STEP_W-1:0] CNT_ONE = STEP_W'(1);

    state_t                  r_state;
    logic [7:0]              r_cause;
    logic [STEP_W-1:0]       r_cnt;
    logic                    r_step_done;
    logic                    r_rsp_valid;
    logic [2:0]              r_rsp_state;
    logic [DATA_WIDTH-1:0]   r_rsp_pc;
    logic [7:0]              r_rsp_cause;

    state_t                  w_state_nxt;
    logic [7:0]              w_cause_nxt;
    logic [STEP_W-1:0]       w_cnt_nxt;
    logic                    w_step_done_nxt;
    logic                    w_rsp_make;
    logic                    w_exc_fatal;
    logic                    w_exc_trap;
    logic                    w_exc_any;
    logic                    w_pc_we;
    logic                    w_cmd_ready;
    logic                    w_cmd_fire;
    logic [STEP_W-1:0]       w_step_load;

    always_comb begin
        w_exc_fatal = |exception_i[ANOMALY_MSB:0];
        w_exc_trap  = exception_i[ECALL_BIT] | exception_i[EBREAK_BIT];
        w_exc_any   = (exception_i != 8'd0);
        w_pc_we     = ((r_state == S_RUN) || (r_state == S_STEP)) && !w_exc_any;
        // A cycle with any exception in RUN belongs to the exception path, so
        // no command is taken alongside it; this keeps exactly one response
        // per accepted command.
        w_cmd_ready = !r_rsp_valid && !r_step_done &&
                      ((r_state == S_HALT) || (r_state == S_ERROR) ||
                       ((r_state == S_RUN) && !w_exc_any));
        w_cmd_fire  = cmd_valid_i && w_cmd_ready;
        w_step_load = (cmd_arg_i == '0) ? CNT_ONE : cmd_arg_i;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cause_nxt     = r_cause;
        w_cnt_nxt       = r_cnt;
        w_step_done_nxt = r_step_done;
        w_rsp_make      = 1'b0;

        case (r_state)
            S_RST: begin
                w_state_nxt = S_RUN;
            end

            S_RUN: begin
                if (w_exc_fatal) begin
                    w_state_nxt = S_ERROR;
                    w_cause_nxt = exception_i;
                end else if (w_exc_trap) begin
                    w_state_nxt = S_HALT;
                    w_cause_nxt = exception_i;
                    // Unsolicited; lost if the host still owes us an accept.
                    w_rsp_make  = !r_rsp_valid;
                end else if (w_cmd_fire) begin
                    case (cmd_op_i)
                        OP_HALT: begin
                            w_state_nxt = S_HALT;
                            w_cause_nxt = 8'd0;
                            w_rsp_make  = 1'b1;
                        end
                        OP_STEP: begin
                            // Halt and step folded into one command; the
                            // response comes when the step finishes.
                            w_state_nxt = S_STEP;
                            w_cause_nxt = 8'd0;
                            w_cnt_nxt   = w_step_load;
                        end
                        default: begin
                            w_rsp_make = 1'b1;
                        end
                    endcase
                end
            end

            S_HALT: begin
                if (r_step_done) begin
                    // One cycle after the last step commit, so pc_i already
                    // shows the post-commit PC.
                    w_step_done_nxt = 1'b0;
                    w_rsp_make      = 1'b1;
                end else if (w_cmd_fire) begin
                    case (cmd_op_i)
                        OP_RESUME: begin
                            w_state_nxt = S_RUN;
                            w_cause_nxt = 8'd0;
                            w_rsp_make  = 1'b1;
                        end
                        OP_STEP: begin
                            w_state_nxt = S_STEP;
                            w_cnt_nxt   = w_step_load;
                        end
                        default: begin
                            w_rsp_make = 1'b1;
                        end
                    endcase
                end
            end

            S_ERROR: begin
                if (w_cmd_fire) begin
                    w_rsp_make = 1'b1;
                end
            end

            S_STEP: begin
                if (w_exc_fatal) begin
                    w_state_nxt = S_ERROR;
                    w_cause_nxt = exception_i;
                    w_cnt_nxt   = '0;
                    w_rsp_make  = 1'b1;
                end else if (w_exc_trap) begin
                    w_state_nxt = S_HALT;
                    w_cause_nxt = exception_i;
                    w_cnt_nxt   = '0;
                    w_rsp_make  = 1'b1;
                end else if (w_pc_we) begin
                    w_cnt_nxt = (r_cnt == '0) ? '0 : (r_cnt - CNT_ONE);
                    if (r_cnt <= CNT_ONE) begin
                        w_state_nxt     = S_HALT;
                        w_step_done_nxt = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_RST;
            r_cause     <= 8'd0;
            r_cnt       <= '0;
            r_step_done <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_state <= 3'd0;
            r_rsp_pc    <= '0;
            r_rsp_cause <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cause     <= w_cause_nxt;
            r_cnt       <= w_cnt_nxt;
            r_step_done <= w_step_done_nxt;
            if (w_rsp_make) begin
                r_rsp_valid <= 1'b1;
                r_rsp_state <= w_state_nxt;
                r_rsp_pc    <= pc_i;
                r_rsp_cause <= w_cause_nxt;
            end else if (rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign cmd_ready_o = w_cmd_ready;
    assign pc_we_o     = w_pc_we;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_state_o = r_rsp_state;
    assign rsp_pc_o    = r_rsp_pc;
    assign rsp_cause_o = r_rsp_cause;
    assign halted_o    = (r_state == S_HALT) || (r_state == S_ERROR);

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

    localparam int DW = 64;
    localparam logic [1:0] OP_STATUS = 2'd0;
    localparam logic [1:0] OP_HALT   = 2'd1;
    localparam logic [1:0] OP_RESUME = 2'd2;
    localparam logic [1:0] OP_STEP   = 2'd3;
    localparam int M_RUN = 1, M_HALT = 2, M_ERR = 3;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [1:0]    cmd_op_i;
    logic [15:0]   cmd_arg_i;
    logic [7:0]    exception_i;
    logic [DW-1:0] pc_i;
    logic          pc_we_o;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [2:0]    rsp_state_o;
    logic [DW-1:0] rsp_pc_o;
    logic [7:0]    rsp_cause_o;
    logic          halted_o;

    always #5 clk_i = ~clk_i;

    run_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_arg_i(cmd_arg_i),
        .exception_i(exception_i), .pc_i(pc_i), .pc_we_o(pc_we_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_state_o(rsp_state_o), .rsp_pc_o(rsp_pc_o),
        .rsp_cause_o(rsp_cause_o), .halted_o(halted_o)
    );

    // The bench plays the PC register: it advances by 4 on every commit.
    logic [DW-1:0] tb_pc = 64'h0000_0000_8000_0000;
    int commits = 0;
    assign pc_i = tb_pc;
    always @(posedge clk_i) begin
        if (pc_we_o === 1'b1) begin
            tb_pc   <= tb_pc + 64'd4;
            commits <= commits + 1;
        end
    end

    int total = 0;
    int bad   = 0;
    int m_state;
    logic [7:0] m_cause;

    // Reference: state the debug host should see after a command.
    function automatic int model_next(input int st, input logic [1:0] op);
        if (st == M_ERR) return M_ERR;
        case (op)
            OP_HALT:   return M_HALT;
            OP_RESUME: return M_RUN;
            OP_STEP:   return M_HALT;
            default:   return st;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk_i); #1;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [15:0] arg,
                          output bit ok, output logic [DW-1:0] acc_pc);
        ok = 1'b0;
        acc_pc = '0;
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_arg_i = arg;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk_i);
            if (cmd_ready_o === 1'b1) begin ok = 1'b1; acc_pc = pc_i; end
            @(posedge clk_i); #1;
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic get_rsp(input int delay, output bit ok, output logic [2:0] st,
                           output logic [DW-1:0] pc, output logic [7:0] cause);
        ok = 1'b0; st = '0; pc = '0; cause = '0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o === 1'b1) begin
                ok = 1'b1; st = rsp_state_o; pc = rsp_pc_o; cause = rsp_cause_o;
            end else begin
                @(posedge clk_i); #1;
            end
        end
        if (ok) begin
            repeat (delay) begin @(posedge clk_i); @(negedge clk_i); end
            rsp_ready_i = 1'b1;
            @(posedge clk_i); #1;
            rsp_ready_i = 1'b0;
        end
    endtask

    // Issue a command, collect its response and compare against the model.
    task automatic cmd_expect(input string name, input logic [1:0] op, input logic [15:0] arg,
                              input int delay);
        bit ok; logic [DW-1:0] acc_pc, pc0, exp_pc; logic [2:0] st; logic [DW-1:0] rpc;
        logic [7:0] cause; int c0, n, exp_st;
        pc0 = tb_pc; c0 = commits;
        n = (arg == 16'd0) ? 1 : int'(arg);
        exp_st = model_next(m_state, op);
        do_cmd(op, arg, ok, acc_pc);
        total++;
        if (!ok) begin bad++; $display("FAIL %s_accept: cmd_ready never seen", name); return; end
        get_rsp(delay, ok, st, rpc, cause);
        total++;
        if (!ok) begin bad++; $display("FAIL %s_rsp: timeout waiting rsp_valid", name); return; end
        if (m_state != M_ERR && (op == OP_HALT || op == OP_RESUME)) m_cause = 8'd0;
        exp_pc = (m_state == M_HALT && op == OP_STEP) ? pc0 + 64'(4 * n) : acc_pc;
        total++;
        if (st !== 3'(exp_st)) begin bad++; $display("FAIL %s_state: got=%0d want=%0d", name, st, exp_st); end
        total++;
        if (cause !== m_cause) begin bad++; $display("FAIL %s_cause: got=%0h want=%0h", name, cause, m_cause); end
        total++;
        if (rpc !== exp_pc) begin bad++; $display("FAIL %s_pc: got=%0h want=%0h", name, rpc, exp_pc); end
        if (m_state == M_HALT && op == OP_STEP) begin
            total++;
            if (commits - c0 != n) begin bad++; $display("FAIL %s_commits: got=%0d want=%0d", name, commits - c0, n); end
        end
        if (m_state == M_ERR) begin
            total++;
            if (commits != c0) begin bad++; $display("FAIL %s_err_commit: got=%0d want=0", name, commits - c0); end
        end
        m_state = exp_st;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_arg_i = '0;
        exception_i = '0; rsp_ready_i = 1'b0;
        repeat (3) cyc();
        @(negedge clk_i);
        total++;
        if ({pc_we_o, cmd_ready_o, rsp_valid_o, halted_o} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl: got=%b want=0000", {pc_we_o, cmd_ready_o, rsp_valid_o, halted_o});
        end
        total++;
        if ({rsp_state_o, rsp_cause_o, rsp_pc_o} !== '0) begin
            bad++; $display("FAIL reset_rsp: state=%0d cause=%0h pc=%0h want 0", rsp_state_o, rsp_cause_o, rsp_pc_o);
        end
        @(posedge clk_i); #1; rst_i = 1'b0;
        @(negedge clk_i);
        total++;
        if (pc_we_o !== 1'b0) begin bad++; $display("FAIL rel_cycle1_pc_we: got=%b want=0", pc_we_o); end
        @(posedge clk_i); #1;
        @(negedge clk_i);
        total++;
        if (pc_we_o !== 1'b1) begin bad++; $display("FAIL rel_cycle2_pc_we: got=%b want=1", pc_we_o); end
        total++;
        if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL rel_cycle2_ready: got=%b want=1", cmd_ready_o); end
        @(posedge clk_i); #1;
        m_state = M_RUN; m_cause = 8'd0;
        cmd_expect("reset_status", OP_STATUS, 16'd0, 0);
    endtask

    task automatic test_halt_step();
        logic [15:0] args[4];
        int c0;
        args[0] = 16'd3; args[1] = 16'd0;
        args[2] = 16'($urandom_range(1, 12)); args[3] = 16'($urandom_range(2, 12));
        for (int k = 0; k < 4; k++) begin
            cmd_expect("hs_halt", OP_HALT, 16'd0, int'($urandom_range(0, 2)));
            cmd_expect("hs_step", OP_STEP, args[k], int'($urandom_range(0, 3)));
            total++;
            if (halted_o !== 1'b1) begin bad++; $display("FAIL hs_halted: got=%b want=1", halted_o); end
            c0 = commits;
            repeat (3) cyc();
            total++;
            if (commits != c0) begin bad++; $display("FAIL hs_extra_commit: got=%0d want=0", commits - c0); end
        end
        cmd_expect("hs_resume", OP_RESUME, 16'd0, 0);
    endtask

    task automatic test_trap();
        logic [7:0] vals[2];
        logic [DW-1:0] p, rpc; logic [2:0] st; logic [7:0] cause; bit ok;
        vals[0] = 8'h10; vals[1] = 8'h08;
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(1, 4)) cyc();
            exception_i = vals[k]; p = tb_pc;
            @(negedge clk_i);
            total++;
            if (pc_we_o !== 1'b0) begin bad++; $display("FAIL trap_pc_we: got=%b want=0", pc_we_o); end
            @(posedge clk_i); #1; exception_i = 8'd0;
            get_rsp(int'($urandom_range(0, 2)), ok, st, rpc, cause);
            total++;
            if (!ok) begin
                bad++; $display("FAIL trap_unsol: timeout waiting rsp_valid");
            end else if ({st, cause, rpc} !== {3'(M_HALT), vals[k], p}) begin
                bad++; $display("FAIL trap_unsol: got st=%0d cause=%0h pc=%0h want st=2 cause=%0h pc=%0h",
                                st, cause, rpc, vals[k], p);
            end
            total++;
            if (tb_pc !== p) begin bad++; $display("FAIL trap_pc_hold: got=%0h want=%0h", tb_pc, p); end
            m_state = M_HALT; m_cause = vals[k];
            cmd_expect("trap_status", OP_STATUS, 16'd0, 0);
            cmd_expect("trap_resume", OP_RESUME, 16'd0, 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op; logic [15:0] arg;
        for (int k = 0; k < 16; k++) begin
            op = 2'($urandom_range(0, 3));
            if (op == OP_STEP && m_state == M_RUN) op = OP_HALT;
            arg = 16'($urandom_range(0, 5));
            cmd_expect("b2b", op, arg, int'($urandom_range(0, 3)));
        end
        if (m_state == M_RUN) cmd_expect("b2b_halt", OP_HALT, 16'd0, 0);
    endtask

    task automatic test_fatal_step();
        logic [DW-1:0] pc0, rpc, exp_pc; logic [2:0] st; logic [7:0] cause; bit ok;
        int c0, k; logic [1:0] ops[4];
        pc0 = tb_pc; c0 = commits;
        k = int'($urandom_range(1, 3));
        do_cmd(OP_STEP, 16'd5, ok, rpc);
        total++;
        if (!ok) begin bad++; $display("FAIL fstep_accept: cmd_ready never seen"); end
        repeat (k) cyc();
        exception_i = 8'h04;
        @(negedge clk_i);
        total++;
        if (pc_we_o !== 1'b0) begin bad++; $display("FAIL fstep_pc_we: got=%b want=0", pc_we_o); end
        @(posedge clk_i); #1; exception_i = 8'd0;
        get_rsp(0, ok, st, rpc, cause);
        exp_pc = pc0 + 64'(4 * k);
        total++;
        if (!ok || {st, cause, rpc} !== {3'(M_ERR), 8'h04, exp_pc}) begin
            bad++; $display("FAIL fstep_rsp: ok=%0d st=%0d cause=%0h pc=%0h want st=3 cause=04 pc=%0h",
                            ok, st, cause, rpc, exp_pc);
        end
        total++;
        if (commits - c0 != k) begin bad++; $display("FAIL fstep_commits: got=%0d want=%0d", commits - c0, k); end
        m_state = M_ERR; m_cause = 8'h04;
        ops[0] = OP_RESUME; ops[1] = OP_STATUS; ops[2] = OP_HALT; ops[3] = OP_STEP;
        for (int i = 0; i < 4; i++) cmd_expect("err_cmd", ops[i], 16'd2, int'($urandom_range(0, 2)));
        repeat (3) cyc();
        total++;
        if (halted_o !== 1'b1) begin bad++; $display("FAIL err_halted: got=%b want=1", halted_o); end
    endtask

    task automatic test_stall_and_reset();
        bit ok; logic [DW-1:0] acc_pc; int seen;
        rst_i = 1'b1; cyc(); cyc(); rst_i = 1'b0; cyc(); cyc();
        m_state = M_RUN; m_cause = 8'd0;
        do_cmd(OP_STATUS, 16'd0, ok, acc_pc);
        total++;
        if (!ok) begin bad++; $display("FAIL stall_accept: cmd_ready never seen"); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) exception_i = 8'h08;
            @(negedge clk_i);
            total++;
            if ({rsp_valid_o, cmd_ready_o, rsp_state_o, rsp_cause_o, rsp_pc_o} !==
                {1'b1, 1'b0, 3'(M_RUN), 8'h00, acc_pc}) begin
                bad++; $display("FAIL stall_hold: v=%b rdy=%b st=%0d cause=%0h pc=%0h want v=1 rdy=0 st=1 cause=0 pc=%0h",
                                rsp_valid_o, cmd_ready_o, rsp_state_o, rsp_cause_o, rsp_pc_o, acc_pc);
            end
            @(posedge clk_i); #1; exception_i = 8'd0;
        end
        rsp_ready_i = 1'b1; cyc(); rsp_ready_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i); if (rsp_valid_o !== 1'b0) seen++;
            @(posedge clk_i); #1;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL trap_dropped: rsp_valid cycles=%0d want=0", seen); end
        total++;
        if (halted_o !== 1'b1) begin bad++; $display("FAIL trap_pending_halted: got=%b want=1", halted_o); end
        m_state = M_HALT; m_cause = 8'h08;
        cmd_expect("stall_status", OP_STATUS, 16'd0, 0);

        do_cmd(OP_STATUS, 16'd0, ok, acc_pc);
        rst_i = 1'b1; cyc();
        total++;
        if ({rsp_valid_o, halted_o, cmd_ready_o, pc_we_o, rsp_state_o, rsp_cause_o, rsp_pc_o} !== '0) begin
            bad++; $display("FAIL rst_mid_rsp: v=%b h=%b st=%0d cause=%0h pc=%0h want all 0",
                            rsp_valid_o, halted_o, rsp_state_o, rsp_cause_o, rsp_pc_o);
        end
        rst_i = 1'b0; cyc(); cyc();
        m_state = M_RUN; m_cause = 8'd0;
        cmd_expect("rst_halt", OP_HALT, 16'd0, 0);
        do_cmd(OP_STEP, 16'd20, ok, acc_pc);
        repeat (3) cyc();
        rst_i = 1'b1; cyc();
        total++;
        if ({pc_we_o, halted_o, rsp_valid_o} !== 3'b000) begin
            bad++; $display("FAIL rst_mid_step: pc_we=%b h=%b v=%b want 000", pc_we_o, halted_o, rsp_valid_o);
        end
        rst_i = 1'b0; cyc(); cyc();
        total++;
        if ({pc_we_o, rsp_valid_o} !== 2'b10) begin
            bad++; $display("FAIL rst_step_rerun: pc_we=%b v=%b want pc_we=1 v=0", pc_we_o, rsp_valid_o);
        end
        m_state = M_RUN; m_cause = 8'd0;
        cmd_expect("rst_status", OP_STATUS, 16'd0, 0);
    endtask

    initial begin
        test_reset();
        test_halt_step();
        test_trap();
        test_back_to_back();
        test_fatal_step();
        test_stall_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
